video_scandbl: RTL and testbench
================================

// Module: video_scandbl
// PURPOSE
//  TV-to-VGA scan doubler feeding the palette/DAC stage: captures each TV-rate line of 8-bit pixel-plex
//  codes plus blank into a ping-pong line buffer, then replays it twice at 2x pixel rate as vgaplex.
//  Also generates vga_line (0 = first pass, 1 = repeat pass, used as PWM phase MSB), vga_blank and vga_hs.
//  Sits between the TV video renderer and the CRAM/PWM output stage; all logic runs on the 28MHz clk.
// PARAMETERS
//  LINE_W   448  max TV pixels per line (buffer depth per bank)
//  ADDR_W   9    buffer address width; 2**ADDR_W >= LINE_W
//  HS_LEN   52   vga_hs pulse length in VGA pixel strobes
// PORTS
//  clk           in   1  system clock, all flops rising edge
//  rst           in   1  synchronous reset, active high
//  tv_stb        in   1  TV pixel strobe (1 clk wide)
//  vga_stb       in   1  VGA pixel strobe, exactly 2x tv_stb rate
//  tv_lstart     in   1  TV line start pulse (1 clk, coincident with or before first tv_stb)
//  vplex_in      in   8  TV pixel-plex code
//  tv_blank      in   1  TV blank for current pixel
//  vgaplex       out  8  VGA-rate pixel-plex code
//  vga_blank     out  1  VGA blank
//  vga_line      out  1  pass select: 0 first, 1 repeat
//  vga_hs        out  1  VGA horizontal sync, active high
//  ovf           out  1  sticky line-overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: vgaplex=0, vga_blank=1, vga_line=0, vga_hs=0, ovf=0, wr_bank=0, wr_addr=0, rd_addr=0,
//   len=0, state=EMPTY.
//  Write side: tv_lstart -> wr_bank toggles, len <= wr_addr (pixels written to the finished line), wr_addr <= 0.
//   Each tv_stb writes {tv_blank,vplex_in} to bank wr_bank at wr_addr, then wr_addr++; at wr_addr==LINE_W
//   further writes are dropped (no wrap), ovf set if enabled. tv_lstart and tv_stb in same clk:
//   line start first, pixel goes to address 0 of the new bank.
//  Read side reads bank !wr_bank. FSM: EMPTY -> RUN on first tv_lstart after reset; RUN only left by rst.
//   EMPTY: outputs held at reset values (blank=1), no reads.
//   RUN: tv_lstart -> rd_addr=0, vga_line=0. Each vga_stb: rd_addr++; when rd_addr==len-1 it wraps to 0
//   and vga_line toggles. Both passes emitted; a third wrap before next tv_lstart holds rd_addr at len-1
//   with vga_blank forced 1 (TV line longer than 2 VGA passes is truncated, never misaligned).
//   len==0: rd_addr held 0, vga_blank=1, vgaplex=0.
//  Latency: buffer read synchronous, 1 clk; outputs registered -> vgaplex/vga_blank valid 2 clk after
//   the vga_stb that addressed them, held until next update.
//  vga_hs: asserted at rd_addr wrap-to-0 (and on tv_lstart in RUN), deasserted after HS_LEN vga_stb.
//  Mid-line rst: everything returns to reset values next clk; buffer contents are not cleared.
// CONFIGURATION
//  VIDEO_SCANDBL_OVF_EN defined: ovf set on any dropped write, cleared only by rst.
//  Undefined: ovf tied 0, no overflow logic; dropping of excess pixels unchanged.
// STRUCTURE
//  Shared include video_defs.vh: FSM state encodings (EMPTY, RUN), LINE_W/ADDR_W defaults.
//  Sub-module video_scandbl_ram: 2*LINE_W x 9 simple dual-port RAM, {bank,addr} addressing,
//   write on clk, registered read address, unregistered q.
// TESTING
//  Reset then 448 tv_stb with incrementing vplex, tv_blank=0 -> no output until 2nd tv_lstart; outputs blank=1.
//  Line of 448 codes 0..447 mod 256 -> vgaplex 0..191,.. sequence twice, vga_line 0 then 1, hs at each pass start.
//  Write 460 pixels in one line -> only 448 stored, replay length 448, ovf=1 with macro, 0 without.
//  tv_lstart twice with no tv_stb -> len=0, vga_blank=1, vgaplex=0, rd_addr stays 0.
//  tv_blank=1 on pixels 0..31 -> vga_blank=1 for first 32 vga_stb of each pass, 0 after.
//  rst asserted mid-replay -> next clk all outputs at reset values, state EMPTY until next tv_lstart.

Source files
------------

// File: rtl/video_scandbl_pkg.sv
// rtl/video_scandbl_pkg.sv - shared defaults and FSM state encoding for the scan doubler
package video_scandbl_pkg;

  // Default geometry: max TV pixels per line, buffer address width, VGA hsync length
  localparam int DEF_LINE_W = 448;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_HS_LEN = 52;

  typedef enum logic {
    ST_EMPTY = 1'b0,  // no aligned line seen since reset, outputs parked
    ST_RUN   = 1'b1   // replaying the previous TV line twice per TV line
  } state_e;

endpackage

// File: rtl/video_scandbl_if.sv
// rtl/video_scandbl_if.sv - TV renderer to scan doubler pixel bus
// Signals: tv_stb (pixel strobe), tv_lstart (line start), vplex_in (8-bit pixel-plex), tv_blank.
// master = TV renderer side, slave = scan doubler side.
interface video_scandbl_if;
  logic       tv_stb;
  logic       tv_lstart;
  logic [7:0] vplex_in;
  logic       tv_blank;

  modport master (output tv_stb, output tv_lstart, output vplex_in, output tv_blank);
  modport slave  (input  tv_stb, input  tv_lstart, input  vplex_in, input  tv_blank);
endinterface

// File: rtl/video_scandbl_ram.sv
// rtl/video_scandbl_ram.sv - ping-pong line buffer, simple dual-port, {bank,addr} addressed
// Ports: clk; we/waddr/wdata write port; raddr read address (registered here); q unregistered data.
module video_scandbl_ram #(
  parameter int ADDR_W = 9
) (
  input  logic            clk,
  input  logic            we,
  input  logic [ADDR_W:0] waddr,
  input  logic [8:0]      wdata,
  input  logic [ADDR_W:0] raddr,
  output logic [8:0]      q
);
  // Full power-of-two depth so {bank,addr} indexes directly without a multiply
  logic [8:0]      mem [2**(ADDR_W+1)];
  logic [ADDR_W:0] raddr_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    raddr_q <= raddr;
  end

  assign q = mem[raddr_q];
endmodule

// File: rtl/video_scandbl.sv
// rtl/video_scandbl.sv - TV-to-VGA scan doubler: captures a TV line, replays it twice at 2x rate
// Ports: clk, rst (sync, active high); tv (video_scandbl_if.slave) TV pixel input bus;
//  vga_stb VGA pixel strobe; vgaplex/vga_blank/vga_line/vga_hs VGA-rate outputs; ovf sticky overflow.
// Option macro: VIDEO_SCANDBL_OVF_EN enables the sticky ovf flag (otherwise ovf is tied 0).
module video_scandbl
  import video_scandbl_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int HS_LEN = DEF_HS_LEN
) (
  input  logic           clk,
  input  logic           rst,
  video_scandbl_if.slave tv,
  input  logic           vga_stb,
  output logic [7:0]     vgaplex,
  output logic           vga_blank,
  output logic           vga_line,
  output logic           vga_hs,
  output logic           ovf
);
  localparam int              HS_W     = $clog2(HS_LEN + 1);
  localparam logic [ADDR_W:0] LINE_W_C = (ADDR_W+1)'(LINE_W);
  localparam logic [ADDR_W:0] ONE_W    = (ADDR_W+1)'(1);
  localparam logic [HS_W-1:0] HS_LEN_C = HS_W'(HS_LEN);
  localparam logic [HS_W-1:0] ONE_HS   = HS_W'(1);

  state_e            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d, len_q, len_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              pass_q, pass_d, done_q, done_d;
  // Tag travelling alongside the RAM read so output fields line up with their pixel
  logic              tag_vld_q, tag_vld_d, tag_line_q, tag_line_d;
  logic              tag_force_q, tag_force_d, tag_zero_q, tag_zero_d;
  logic [HS_W-1:0]   hs_cnt_q, hs_cnt_d;
  logic              hs_q, hs_d;
  logic [7:0]        plex_q, plex_d;
  logic              blank_q, blank_d, line_q, line_d;
  logic              we;
  logic [ADDR_W:0]   waddr, raddr;
  logic [8:0]        q;
  logic              hs_load;

  video_scandbl_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata ({tv.tv_blank, tv.vplex_in}),
    .raddr (raddr),
    .q     (q)
  );

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    len_d       = len_q;
    rd_addr_d   = rd_addr_q;
    pass_d      = pass_q;
    done_d      = done_q;
    tag_vld_d   = 1'b0;
    tag_line_d  = tag_line_q;
    tag_force_d = tag_force_q;
    tag_zero_d  = tag_zero_q;
    hs_cnt_d    = hs_cnt_q;
    hs_d        = hs_q;
    plex_d      = plex_q;
    blank_d     = blank_q;
    line_d      = line_q;
    we          = 1'b0;
    waddr       = '0;
    raddr       = {~wr_bank_q, rd_addr_q};
    hs_load     = 1'b0;

    // Write side. Line start is applied before a coincident pixel so that pixel lands at 0.
    if (tv.tv_lstart) begin
      wr_bank_d = ~wr_bank_q;
      // The partial line captured before the first line start is not aligned: replay nothing.
      len_d     = (state_q == ST_EMPTY) ? '0 : wr_addr_q;
      wr_addr_d = '0;
      state_d   = ST_RUN;
    end
    if (tv.tv_stb && (wr_addr_d < LINE_W_C)) begin
      we        = 1'b1;
      waddr     = {wr_bank_d, wr_addr_d[ADDR_W-1:0]};
      wr_addr_d = wr_addr_d + ONE_W;
    end

    // Read side: each vga_stb emits the pixel at rd_addr, then advances.
    if (state_q == ST_RUN) begin
      if (tv.tv_lstart) begin
        rd_addr_d = '0;
        pass_d    = 1'b0;
        done_d    = 1'b0;
        hs_load   = 1'b1;
      end else if (vga_stb) begin
        tag_vld_d   = 1'b1;
        tag_line_d  = pass_q;
        tag_force_d = done_q || (len_q == '0);
        tag_zero_d  = (len_q == '0);
        if (len_q == '0) begin
          rd_addr_d = '0;
        end else if (!done_q) begin
          if ({1'b0, rd_addr_q} == len_q - ONE_W) begin
            // First pass wraps into the repeat pass; after the repeat pass the
            // address parks on the last pixel and further strobes emit blank.
            if (!pass_q) begin
              rd_addr_d = '0;
              pass_d    = 1'b1;
              hs_load   = 1'b1;
            end else begin
              done_d    = 1'b1;
            end
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
    end

    if (hs_load) begin
      hs_d     = 1'b1;
      hs_cnt_d = HS_LEN_C;
    end else if (vga_stb && hs_q) begin
      if (hs_cnt_q == ONE_HS) begin
        hs_d     = 1'b0;
        hs_cnt_d = '0;
      end else begin
        hs_cnt_d = hs_cnt_q - ONE_HS;
      end
    end

    // Output register: loads one clk after the strobe, once RAM data is available
    if (tag_vld_q) begin
      plex_d  = tag_zero_q ? 8'd0 : q[7:0];
      blank_d = tag_force_q | q[8];
      line_d  = tag_line_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      len_q       <= '0;
      rd_addr_q   <= '0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
      tag_vld_q   <= 1'b0;
      tag_line_q  <= 1'b0;
      tag_force_q <= 1'b1;
      tag_zero_q  <= 1'b1;
      hs_cnt_q    <= '0;
      hs_q        <= 1'b0;
      plex_q      <= 8'd0;
      blank_q     <= 1'b1;
      line_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      len_q       <= len_d;
      rd_addr_q   <= rd_addr_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
      tag_vld_q   <= tag_vld_d;
      tag_line_q  <= tag_line_d;
      tag_force_q <= tag_force_d;
      tag_zero_q  <= tag_zero_d;
      hs_cnt_q    <= hs_cnt_d;
      hs_q        <= hs_d;
      plex_q      <= plex_d;
      blank_q     <= blank_d;
      line_q      <= line_d;
    end
  end

  assign vgaplex   = plex_q;
  assign vga_blank = blank_q;
  assign vga_line  = line_q;
  assign vga_hs    = hs_q;

`ifdef VIDEO_SCANDBL_OVF_EN
  logic ovf_q, ovf_d;
  always_comb begin
    ovf_d = ovf_q;
    if (tv.tv_stb && !tv.tv_lstart && (wr_addr_q >= LINE_W_C)) ovf_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_video_scandbl.sv
// tb/tb_video_scandbl.sv - self-checking bench for video_scandbl
module tb_video_scandbl;
  localparam int LW  = 448;
  localparam int HSL = 52;
`ifdef VIDEO_SCANDBL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       vga_stb;
  logic [7:0] vgaplex;
  logic       vga_blank, vga_line, vga_hs, ovf;

  video_scandbl_if tvif ();

  video_scandbl dut (
    .clk       (clk),
    .rst       (rst),
    .tv        (tvif),
    .vga_stb   (vga_stb),
    .vgaplex   (vgaplex),
    .vga_blank (vga_blank),
    .vga_line  (vga_line),
    .vga_hs    (vga_hs),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: captured pixels of the line being written and of the line being replayed
  bit         m_empty;
  int         m_wr_cnt;
  logic [8:0] m_cur [LW];
  logic [8:0] m_rep [LW];
  int         m_rep_len;
  bit         m_hs_start;
  int         m_k;

  typedef struct {
    int n;        // TV pixels in this line
    int nblank;   // leading pixels with tv_blank=1
    int pat;      // 0: codes i mod 256, 1: random codes and blank
    bit merge;    // first pixel coincident with tv_lstart
    bit exp_ovf;  // sticky ovf after this line when overflow detection is built in
  } row_t;
  row_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit lst, input bit ts, input bit vs, input logic [8:0] pix);
    tvif.tv_lstart = lst;
    tvif.tv_stb    = ts;
    tvif.tv_blank  = pix[8];
    tvif.vplex_in  = pix[7:0];
    vga_stb        = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_empty = 1'b1; m_wr_cnt = 0; m_rep_len = 0; m_hs_start = 1'b0; m_k = 0;
  endtask

  task automatic m_write(input logic [8:0] pix);
    if (m_wr_cnt < LW) begin
      m_cur[m_wr_cnt] = pix;
      m_wr_cnt++;
    end
  endtask

  task automatic m_lstart();
    m_rep_len  = m_empty ? 0 : m_wr_cnt;
    m_rep      = m_cur;
    m_hs_start = !m_empty;
    m_empty    = 1'b0;
    m_wr_cnt   = 0;
    m_k        = 0;
  endtask

  // Expected output for the k-th VGA strobe since the last line start
  task automatic expect_emit(input int k, output logic [7:0] p, output logic b,
                             output logic l, output logic h, output bit pcare);
    int n;
    n = m_rep_len; p = 8'd0; b = 1'b1; l = 1'b0; pcare = 1'b1;
    if (m_empty) begin
      h = 1'b0;
      return;
    end
    h = (m_hs_start && k < HSL - 1) || (n > 0 && k >= n - 1 && k - (n - 1) < HSL);
    if (n == 0) begin
    end else if (k < n) begin
      p = m_rep[k][7:0]; b = m_rep[k][8];
    end else if (k < 2 * n) begin
      p = m_rep[k-n][7:0]; b = m_rep[k-n][8]; l = 1'b1;
    end else begin
      l = 1'b1; pcare = 1'b0;
    end
  endtask

  task automatic vga_slot(input bit ts, input logic [8:0] pix);
    logic [7:0] ep;
    logic       eb, el, eh;
    bit         pc;
    expect_emit(m_k, ep, eb, el, eh, pc);
    cyc(1'b0, ts, 1'b1, pix);
    if (ts) m_write(pix);
    cyc(1'b0, 1'b0, 1'b0, 9'd0);
    if (pc) check("vgaplex", vgaplex, ep);
    check("vga_blank", vga_blank, eb);
    check("vga_line", vga_line, el);
    check("vga_hs", vga_hs, eh);
    if (!m_empty) m_k++;
  endtask

  task automatic run_line(input int n, input int nblank, input int pat, input bit merge);
    logic [8:0] pl [512];
    for (int i = 0; i < n; i++) begin
      pl[i][8]   = (i < nblank) ? 1'b1 : (pat != 0 ? 1'($urandom_range(0, 1)) : 1'b0);
      pl[i][7:0] = (pat != 0) ? 8'($urandom_range(0, 255)) : 8'(i % 256);
    end
    if (merge && n > 0) begin
      cyc(1'b1, 1'b1, 1'b0, pl[0]);
      m_lstart();
      m_write(pl[0]);
    end else begin
      cyc(1'b1, 1'b0, 1'b0, 9'd0);
      m_lstart();
    end
    for (int i = 0; i < n; i++) begin
      vga_slot(!(merge && i == 0), pl[i]);
      vga_slot(1'b0, 9'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vgaplex"}, vgaplex, 8'd0);
    check({tag, "_blank"}, vga_blank, 1'b1);
    check({tag, "_line"}, vga_line, 1'b0);
    check({tag, "_hs"}, vga_hs, 1'b0);
    check({tag, "_ovf"}, ovf, 1'b0);
  endtask

  initial begin
    tbl[0] = '{448, 0,  0, 1'b0, 1'b0};
    tbl[1] = '{448, 0,  0, 1'b0, 1'b0};
    tbl[2] = '{460, 0,  0, 1'b0, 1'b1};
    tbl[3] = '{0,   0,  0, 1'b0, 1'b1};
    tbl[4] = '{100, 0,  1, 1'b0, 1'b1};
    tbl[5] = '{448, 32, 0, 1'b0, 1'b1};
    tbl[6] = '{448, 0,  1, 1'b1, 1'b1};
    tbl[7] = '{1,   0,  1, 1'b0, 1'b1};
    tbl[8] = '{30,  0,  1, 1'b0, 1'b1};
    tbl[9] = '{200, 5,  1, 1'b1, 1'b1};

    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 9'd0);
    cyc(1'b0, 1'b0, 1'b0, 9'd0);
    rst = 1'b0;
    m_reset();
    cyc(1'b0, 1'b0, 1'b0, 9'd0);
    check_reset_outputs("reset");

    // A full line before any line start: nothing may come out
    for (int i = 0; i < LW; i++) begin
      vga_slot(1'b1, {1'b0, 8'(i % 256)});
      vga_slot(1'b0, 9'd0);
    end

    for (int r = 0; r < 10; r++) begin
      run_line(tbl[r].n, tbl[r].nblank, tbl[r].pat, tbl[r].merge);
      check($sformatf("ovf_row%0d", r), ovf, OVF_EN ? tbl[r].exp_ovf : 1'b0);
    end

    // Reset in the middle of a replay, with a read still in flight
    run_line(40, 0, 1, 1'b0);
    for (int i = 0; i < 20; i++) vga_slot(1'b1, 9'(i));
    cyc(1'b0, 1'b1, 1'b1, 9'h0aa);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 9'd0);
    check_reset_outputs("midrst");
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 10; i++) vga_slot(1'b1, 9'(i));
    run_line(50, 3, 1, 1'b0);
    run_line(50, 0, 1, 1'b1);
    check("ovf_after_rst", ovf, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
